// File: rtl/cpu_exec_stage.sv
// cpu_exec_stage: three-cycle execute/writeback stage with a 4x8 register file, driving an external ALU
module cpu_exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_ope,
  output logic        alu_cin,
  input  logic [7:0]  alu_result,
  input  logic        alu_z,
  input  logic        alu_c,
  output logic        z_flag,
  output logic        c_flag,
  output logic        wb_valid,
  output logic [1:0]  wb_reg,
  output logic [7:0]  wb_data,
  output logic        illegal,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state, state_nx;
  logic [15:0] ir;
  logic [7:0]  rf [4];
  logic [7:0]  hold_data;
  logic        hold_z, hold_c;
  logic [3:0]  op;
  logic [1:0]  rd, rs;
  logic        is_alu, is_ldi, is_cmp, is_ill;
  assign op     = ir[15:12];
  assign rd     = ir[11:10];
  assign rs     = ir[9:8];
  assign is_alu = op >= 4'h1 && op <= 4'hA;
  assign is_ldi = op == 4'hB;
  assign is_cmp = op == 4'hC;
  assign is_ill = op >= 4'hD;
  assign dbg_data = rf[dbg_sel];
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state and outputs decoded from state and the latched instruction
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ope     = '0;
    alu_cin     = 1'b0;
    wb_valid    = 1'b0;
    wb_reg      = '0;
    wb_data     = '0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        state_nx    = instr_valid ? EXEC : IDLE;
      end
      EXEC: begin
        alu_a    = rf[rd];
        alu_b    = rf[rs];
        alu_cin  = c_flag;
        alu_ope  = is_alu ? op : (is_cmp ? 4'h2 : 4'h0);
        state_nx = WB;
      end
      WB: begin
        wb_valid = is_alu | is_ldi;
        wb_reg   = rd;
        wb_data  = hold_data;
        illegal  = is_ill;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // instruction latch, ALU capture, register write and flag update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir        <= '0;
      hold_data <= '0;
      hold_z    <= 1'b0;
      hold_c    <= 1'b0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == EXEC) begin
        hold_data <= is_ldi ? ir[7:0] : alu_result;
        hold_z    <= alu_z;
        hold_c    <= alu_c;
      end
      if (state == WB) begin
        if (is_alu || is_ldi) rf[rd] <= hold_data;
        if (is_alu || is_cmp) begin
          z_flag <= hold_z;
          c_flag <= hold_c;
        end
      end
    end
  end
endmodule

// File: doc/cpu_exec_stage.md
# cpu_exec_stage

Multi-cycle execute/writeback stage of the 8-bit CPU, sitting directly upstream of the `cpu_alu` combinational ALU. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 4×8-bit register file. It drives the ALU's operand, opcode and carry-in inputs, captures the ALU result and flags, and then writes back the result and updates the architectural Z/C flag register. It is the sole consumer of ALU outputs.

## Interface

Parameters
- none (data width fixed at 8, register count fixed at 4)

Ports
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `instr_valid`  in  1  upstream has an instruction on `instr`
- `instr`  in  16  [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
- `instr_ready`  out  1  stage can accept an instruction
- `alu_a`  out  8  ALU operand a
- `alu_b`  out  8  ALU operand b
- `alu_ope`  out  4  ALU opcode
- `alu_cin`  out  1  ALU carry-in
- `alu_result`  in  8  ALU result
- `alu_z`  in  1  ALU zero flag
- `alu_c`  in  1  ALU carry flag
- `z_flag`  out  1  architectural zero flag
- `c_flag`  out  1  architectural carry flag
- `wb_valid`  out  1  one-cycle pulse; a register write happens at the end of this cycle
- `wb_reg`  out  2  destination register of that write
- `wb_data`  out  8  value written
- `illegal`  out  1  one-cycle pulse for an undefined opcode
- `dbg_sel`  in  2  debug register select
- `dbg_data`  out  8  combinational read of register `dbg_sel`

## Operation

Opcodes
- 0x0 NOP: no register write, flags unchanged.
- 0x1–0xA (ADD, SUB, AND, OR, ADC, XOR, SHL, SHR, NOTA, NOTB): `rd <= rd op rs`. Z and C are loaded from the ALU.
- 0xB LDI: `rd <= imm`. Flags unchanged.
- 0xC CMP: ALU runs SUB (0x2) on rd and rs. Z and C are updated; no register write.
- 0xD–0xF: illegal. Treated as NOP, and `illegal` pulses.

State machine: IDLE → EXEC → WB → IDLE.
- IDLE
  - `instr_ready` = 1.
  - On `instr_valid & instr_ready` at an edge, latch `instr` and go to EXEC.
  - Otherwise remain in IDLE.
- EXEC
  - `alu_a` = reg[rd], `alu_b` = reg[rs], `alu_cin` = `c_flag`.
  - `alu_ope` = op for 0x1–0xA, 0x2 for CMP, and 0x0 otherwise.
  - At the edge, capture `alu_result`, `alu_z` and `alu_c` (or imm, for LDI) into holding registers, then go to WB.
- WB
  - `wb_valid` = 1 only for ALU ops and LDI.
  - `wb_reg` = rd, `wb_data` = held value.
  - `illegal` = 1 if the op was illegal.
  - At the edge:
    - perform the register write;
    - update the flags (ALU ops and CMP only);
    - go to IDLE.

Other rules
- Outside EXEC: `alu_ope` = 0, `alu_a` = 0, `alu_b` = 0, `alu_cin` = 0.
- `instr_ready` = 0 in EXEC and WB. `instr` and `instr_valid` are ignored in those states.
- rd == rs is legal; both operands read the same register.
- ADC uses the flag value from before this instruction. The flag update at the WB edge affects only later instructions.
- `dbg_data` shows the new value starting the cycle after the WB edge.

Reset (asynchronous, immediate)
- State goes to IDLE.
- All registers and both flags are set to 0.
- Holding registers are set to 0.
- `wb_valid` = 0 and `illegal` = 0.
- `instr_ready` = 1 once `rst` is deasserted.
- Reset during EXEC or WB aborts the instruction: no write, no flag update.

## Timing

- Accept edge T. EXEC during cycle T+1. WB during cycle T+2. Register and flags are updated at the end of T+2.
- `instr_ready` returns to 1 in cycle T+3.
- Throughput is one instruction per 3 cycles. Back-to-back instructions are dependency-safe, so no forwarding is needed.
- The ALU path is combinational within the EXEC cycle: stage output registers → `cpu_alu` → stage capture registers.
- All outputs except `dbg_data` and `instr_ready` are registered or decoded from the state and held registers.

## Test plan

- Reset
  - Stimulus: assert `rst` mid-EXEC of `LDI r0,0x55`.
  - Required: r0 stays 0x00, no `wb_valid`, Z = C = 0, `instr_ready` = 1 after release.
- ADD with carry and zero
  - Stimulus: `LDI r0,0x0F`, `LDI r1,0xF1`, `ADD r0,r1`.
  - Required: `wb_data` = 0x00 to r0, Z = 1, C = 1.
- ADC carry-in
  - Stimulus: immediately after the ADD above, `ADC r2,r3` with r2 = r3 = 0.
  - Required: `alu_cin` = 1 in EXEC, r2 = 0x01, Z = 0, C = 0.
- CMP
  - Stimulus: r0 = 0x05, r1 = 0x05, `CMP r0,r1`.
  - Required: Z = 1, C = 1, no `wb_valid`, r0 unchanged.
  - Stimulus: r0 = 0x03, `CMP r0,r1`.
  - Required: Z = 0, C = 0.
- Handshake
  - Stimulus: `instr_valid` held high with different instructions changing every cycle.
  - Required: acceptance only at IDLE edges, exactly 3 cycles apart; the `instr` values presented in non-IDLE cycles are ignored.
- Illegal and NOP
  - Stimulus: op 0xE, then op 0x0.
  - Required: `illegal` pulses for one cycle in the WB of 0xE only; no register or flag change for either; `alu_ope` = 0 in both EXEC cycles.
